// File: rtl/audio_codec_stereo.sv
// Master-mode stereo serial audio port: derives BCLK/LRCK from clk, shifts out a
// DAC sample pair and gathers an ADC pair each frame, left-justified or I2S framed.
module audio_codec_stereo #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_BITS    = 16,
  parameter int BCLK_HALF    = 4,
  parameter int I2S_MODE     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              channel_en,
  input  logic [SAMPLE_WIDTH-1:0] tx_data_l,
  input  logic [SAMPLE_WIDTH-1:0] tx_data_r,
  output logic                    tx_ready,
  output logic [SAMPLE_WIDTH-1:0] rx_data_l,
  output logic [SAMPLE_WIDTH-1:0] rx_data_r,
  output logic                    rx_valid,
  output logic                    AUD_BCLK,
  output logic                    AUD_DACLRCK,
  output logic                    AUD_ADCLRCK,
  output logic                    AUD_DACDAT,
  input  logic                    AUD_ADCDAT
);

  localparam int CYC_MAX = 2 * BCLK_HALF - 1;
  localparam int CYC_W   = $clog2(2 * BCLK_HALF);
  localparam int BIT_W   = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam int IDX_W   = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

  if (SLOT_BITS < SAMPLE_WIDTH + I2S_MODE) begin : g_bad_slot
    $error("audio_codec_stereo: SLOT_BITS too small for SAMPLE_WIDTH + I2S_MODE");
  end
  if (BCLK_HALF < 2) begin : g_bad_half
    $error("audio_codec_stereo: BCLK_HALF must be at least 2");
  end

  logic [CYC_W-1:0]        cyc;
  logic [BIT_W-1:0]        bit_cnt;
  logic                    slot;
  logic [SAMPLE_WIDTH-1:0] hold_l;
  logic [SAMPLE_WIDTH-1:0] hold_r;
  logic [SAMPLE_WIDTH-1:0] shadow_l;
  logic [SAMPLE_WIDTH-1:0] shadow_r;
  logic [SAMPLE_WIDTH-1:0] shadow_l_nxt;
  logic [SAMPLE_WIDTH-1:0] shadow_r_nxt;
  logic [SAMPLE_WIDTH-1:0] src_l;
  logic [SAMPLE_WIDTH-1:0] src_r;

  logic             cyc_wrap;
  logic             bit_wrap;
  logic             frame_end;
  logic             pre_end;
  logic             sample_now;
  logic [BIT_W-1:0] bit_next;
  logic             slot_next;

  int               tx_k;
  logic [IDX_W-1:0] tx_idx;
  logic             tx_bit;
  int               rx_k;
  logic [IDX_W-1:0] rx_idx;
  logic             rx_take;

  assign cyc_wrap   = (cyc == CYC_W'(CYC_MAX));
  assign bit_wrap   = (bit_cnt == BIT_W'(SLOT_BITS - 1));
  assign frame_end  = cyc_wrap && bit_wrap && !slot;
  assign pre_end    = (cyc == CYC_W'(CYC_MAX - 1)) && bit_wrap && !slot;
  assign sample_now = (cyc == CYC_W'(BCLK_HALF));
  assign bit_next   = bit_wrap ? '0 : bit_cnt + 1'b1;
  assign slot_next  = bit_wrap ? ~slot : slot;

  assign AUD_BCLK    = (cyc >= CYC_W'(BCLK_HALF));
  assign AUD_DACLRCK = slot;
  assign AUD_ADCLRCK = slot;

  // The bit launched at a frame boundary must come from the pair being captured now.
  always_comb begin
    src_l  = frame_end ? tx_data_l : hold_l;
    src_r  = frame_end ? tx_data_r : hold_r;
    tx_k   = int'(bit_next) - I2S_MODE;
    tx_idx = '0;
    tx_bit = 1'b0;
    if (tx_k >= 0 && tx_k < SAMPLE_WIDTH && channel_en[slot_next]) begin
      tx_idx = IDX_W'(SAMPLE_WIDTH - 1 - tx_k);
      tx_bit = slot_next ? src_l[tx_idx] : src_r[tx_idx];
    end
  end

  // Next shadow value is also what gets published, so a bit sampled on the
  // publishing edge is not lost when BCLK_HALF is small.
  always_comb begin
    rx_k         = int'(bit_cnt) - I2S_MODE;
    rx_take      = sample_now && (rx_k >= 0) && (rx_k < SAMPLE_WIDTH) && channel_en[slot];
    rx_idx       = '0;
    shadow_l_nxt = shadow_l;
    shadow_r_nxt = shadow_r;
    if (cyc_wrap && bit_wrap) begin
      if (slot_next) shadow_l_nxt = '0;
      else           shadow_r_nxt = '0;
    end
    if (rx_take) begin
      rx_idx = IDX_W'(SAMPLE_WIDTH - 1 - rx_k);
      if (slot) shadow_l_nxt[rx_idx] = AUD_ADCDAT;
      else      shadow_r_nxt[rx_idx] = AUD_ADCDAT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc        <= '0;
      bit_cnt    <= '0;
      slot       <= 1'b1;
      hold_l     <= '0;
      hold_r     <= '0;
      shadow_l   <= '0;
      shadow_r   <= '0;
      rx_data_l  <= '0;
      rx_data_r  <= '0;
      tx_ready   <= 1'b0;
      rx_valid   <= 1'b0;
      AUD_DACDAT <= 1'b0;
    end else begin
      cyc <= cyc_wrap ? '0 : cyc + 1'b1;
      if (cyc_wrap) begin
        bit_cnt    <= bit_next;
        slot       <= slot_next;
        AUD_DACDAT <= tx_bit;
      end
      if (frame_end) begin
        hold_l <= tx_data_l;
        hold_r <= tx_data_r;
      end
      shadow_l <= shadow_l_nxt;
      shadow_r <= shadow_r_nxt;
      // Strobes are set one edge early so they are high during the last clk of the frame.
      tx_ready <= pre_end;
      rx_valid <= pre_end;
      if (pre_end) begin
        if (channel_en[1]) rx_data_l <= shadow_l_nxt;
        if (channel_en[0]) rx_data_r <= shadow_r_nxt;
      end
    end
  end

endmodule

// File: tb/tb_audio_codec_stereo.sv
// Bench for audio_codec_stereo: default instance in DAC->ADC loopback with a vector
// table and rx scoreboard, plus an I2S/24-bit instance checked over its second frame.
module tb_audio_codec_stereo;

  localparam int SW     = 16;
  localparam int SLOT   = 16;
  localparam int BH     = 4;
  localparam int BITP   = 2 * BH;
  localparam int FRAME  = 4 * SLOT * BH;
  localparam int SW2    = 24;
  localparam int SLOT2  = 32;
  localparam int FRAME2 = 4 * SLOT2 * BH;

  typedef struct {
    logic [1:0]  en;
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    channel_en;
  logic [SW-1:0] tx_data_l;
  logic [SW-1:0] tx_data_r;
  logic          tx_ready;
  logic [SW-1:0] rx_data_l;
  logic [SW-1:0] rx_data_r;
  logic          rx_valid;
  logic          bclk;
  logic          dac_lrck;
  logic          adc_lrck;
  logic          dacdat;
  logic          adcdat;

  logic [1:0]     en2 = 2'b11;
  logic [SW2-1:0] tx_l2 = 24'h800000;
  logic [SW2-1:0] tx_r2 = 24'h000001;
  logic           tx_ready2;
  logic [SW2-1:0] rx_l2;
  logic [SW2-1:0] rx_r2;
  logic           rx_valid2;
  logic           bclk2;
  logic           dac_lrck2;
  logic           adc_lrck2;
  logic           dac2;
  logic           adc2;

  int        checks = 0;
  int        errors = 0;
  int        t = 0;
  logic      run_chk = 1'b0;
  logic      rel = 1'b0;
  logic [1:0]    m_en = 2'b00;
  logic [SW-1:0] mh_l = '0;
  logic [SW-1:0] mh_r = '0;
  exp_t      sb[$];
  vec_t      vecs[7];

  assign adcdat = dacdat;
  assign adc2   = dac2;

  always #5 clk = ~clk;

  audio_codec_stereo #(.SAMPLE_WIDTH(SW), .SLOT_BITS(SLOT), .BCLK_HALF(BH), .I2S_MODE(0)) dut (
    .clk(clk), .reset(reset), .channel_en(channel_en),
    .tx_data_l(tx_data_l), .tx_data_r(tx_data_r), .tx_ready(tx_ready),
    .rx_data_l(rx_data_l), .rx_data_r(rx_data_r), .rx_valid(rx_valid),
    .AUD_BCLK(bclk), .AUD_DACLRCK(dac_lrck), .AUD_ADCLRCK(adc_lrck),
    .AUD_DACDAT(dacdat), .AUD_ADCDAT(adcdat)
  );

  audio_codec_stereo #(.SAMPLE_WIDTH(SW2), .SLOT_BITS(SLOT2), .BCLK_HALF(BH), .I2S_MODE(1)) dut_i2s (
    .clk(clk), .reset(reset), .channel_en(en2),
    .tx_data_l(tx_l2), .tx_data_r(tx_r2), .tx_ready(tx_ready2),
    .rx_data_l(rx_l2), .rx_data_r(rx_r2), .rx_valid(rx_valid2),
    .AUD_BCLK(bclk2), .AUD_DACLRCK(dac_lrck2), .AUD_ADCLRCK(adc_lrck2),
    .AUD_DACDAT(dac2), .AUD_ADCDAT(adc2)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s t=%0d actual=%h expected=%h", name, t, act, exp);
    end
  endtask

  task automatic check_reset_state();
    check_output("rst_bclk", bclk, 0);
    check_output("rst_lrck", dac_lrck, 1);
    check_output("rst_adclrck", adc_lrck, 1);
    check_output("rst_dacdat", dacdat, 0);
    check_output("rst_tx_ready", tx_ready, 0);
    check_output("rst_rx_valid", rx_valid, 0);
    check_output("rst_rx_l", rx_data_l, 0);
    check_output("rst_rx_r", rx_data_r, 0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    channel_en = v.en;
    tx_data_l  = v.l;
    tx_data_r  = v.r;
    e.l = v.exp_l;
    e.r = v.exp_r;
    sb.push_back(e);
  endtask

  // Frame position, holding registers and per-bit channel enable as seen by the link.
  always @(posedge clk) begin
    if (reset) begin
      t    <= 0;
      mh_l <= '0;
      mh_r <= '0;
      m_en <= 2'b00;
    end else begin
      t <= t + 1;
      if (t % BITP == BITP - 1) m_en <= channel_en;
      if (t % FRAME == FRAME - 1) begin
        mh_l <= tx_data_l;
        mh_r <= tx_data_r;
      end
    end
  end

  // Every cycle: clock shapes, strobes and serial DAC data against the frame position.
  always @(negedge clk) begin
    int   fp;
    int   bi;
    logic sl;
    logic exp_dac;
    if (run_chk) begin
      fp = t % FRAME;
      sl = (fp < FRAME / 2);
      bi = (fp % (FRAME / 2)) / BITP;
      exp_dac = m_en[sl] ? (sl ? mh_l[SW-1-bi] : mh_r[SW-1-bi]) : 1'b0;
      check_output("bclk", bclk, (fp % BITP) >= BH);
      check_output("lrck", dac_lrck, sl);
      check_output("adclrck", adc_lrck, sl);
      check_output("tx_ready", tx_ready, fp == FRAME - 1);
      check_output("rx_valid", rx_valid, fp == FRAME - 1);
      check_output("dacdat", dacdat, exp_dac);
    end
  end

  // Loopback results land at the end of the second frame of each vector.
  always @(negedge clk) begin
    exp_t e;
    if (run_chk && rx_valid && (t % (2 * FRAME)) == 2 * FRAME - 1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_pop t=%0d actual=rx_valid expected=no_pending_entry", t);
      end else begin
        e = sb.pop_front();
        check_output("rx_data_l", rx_data_l, e.l);
        check_output("rx_data_r", rx_data_r, e.r);
      end
    end
  end

  // I2S instance: MSB one BCLK after LRCK edge, LSB of right at bit 24, loopback at end of frame 2.
  initial begin
    int b;
    wait (rel);
    for (int c = 0; c < 2 * FRAME2 + 4; c++) begin
      @(negedge clk);
      if (t < 2 * FRAME2)
        check_output("i2s_tx_ready", tx_ready2, (t % FRAME2) == FRAME2 - 1);
      if (t >= FRAME2 && t < 2 * FRAME2 && (t % BITP) == BH + 1) begin
        b = ((t - FRAME2) % (FRAME2 / 2)) / BITP;
        if (t < FRAME2 + FRAME2 / 2) check_output("i2s_dac_left", dac2, b == 1);
        else                         check_output("i2s_dac_right", dac2, b == 24);
      end
      if (t == 2 * FRAME2 - 1) begin
        check_output("i2s_rx_valid", rx_valid2, 1);
        check_output("i2s_rx_l", rx_l2, 24'h800000);
        check_output("i2s_rx_r", rx_r2, 24'h000001);
      end
    end
  end

  initial begin
    vecs[0] = '{2'b11, 16'hA5C3, 16'h0F0F, 16'hA5C3, 16'h0F0F};
    vecs[1] = '{2'b11, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
    vecs[2] = '{2'b10, 16'h1234, 16'hFFFF, 16'h1234, 16'h7FFE};
    vecs[3] = '{2'b01, 16'hDEAD, 16'hBEEF, 16'h1234, 16'hBEEF};
    vecs[4] = '{2'b00, 16'h0000, 16'h0000, 16'h1234, 16'hBEEF};
    vecs[5] = '{2'b11, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};
    vecs[6] = '{2'b11, 16'h5A5A, 16'hC3C3, 16'h5A5A, 16'hC3C3};

    reset      = 1'b1;
    channel_en = 2'b11;
    tx_data_l  = '0;
    tx_data_r  = '0;
    @(posedge clk);
    run_chk = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    reset = 1'b0;
    rel   = 1'b1;

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i]);
      repeat (2 * FRAME) @(posedge clk);
      #1;
    end

    // One-cycle reset 100 clk into a frame.
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply_stimulus(vecs[6]);
    @(negedge clk);
    check_reset_state();

    repeat (2 * FRAME + 4) @(posedge clk);
    #1;
    check_output("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_codec_stereo.md
Name: audio_codec_stereo

Overview:
- Parametrised successor to the fixed 16-bit codec serialiser.
- Master-mode serial audio interface: generates BCLK and LRCK from the system clock.
- Serialises a stereo DAC sample pair and deserialises a stereo ADC pair.
- Configurable sample width, slot length, clock ratios and left-justified/I2S framing, with per-channel enables and a frame-level handshake; sits between the effects datapath and the codec pins.

Parameters:
- SAMPLE_WIDTH, 16, bits per audio sample (1..32).
- SLOT_BITS, 16, BCLK periods per channel slot; must be >= SAMPLE_WIDTH + I2S_MODE (else elaboration error).
- BCLK_HALF, 4, clk cycles per BCLK half-period (>= 2).
- I2S_MODE, 0, 0 = left-justified (MSB in first bit of slot); 1 = I2S (MSB delayed one BCLK after LRCK edge).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- channel_en  input  2  bit1 = left enable, bit0 = right enable
- tx_data_l  input  SAMPLE_WIDTH  left DAC sample, two's complement
- tx_data_r  input  SAMPLE_WIDTH  right DAC sample
- tx_ready  output  1  one-cycle strobe; tx_data_l/r captured this cycle
- rx_data_l  output  SAMPLE_WIDTH  last complete left ADC sample
- rx_data_r  output  SAMPLE_WIDTH  last complete right ADC sample
- rx_valid  output  1  one-cycle strobe; rx_data_l/r updated this cycle
- AUD_BCLK  output  1  bit clock
- AUD_DACLRCK  output  1  DAC word select, 1 = left slot
- AUD_ADCLRCK  output  1  ADC word select, identical to AUD_DACLRCK
- AUD_DACDAT  output  1  serial DAC data
- AUD_ADCDAT  input  1  serial ADC data

Behaviour:
- Reset is synchronous and active-high; all counters and registers are clocked by clk.
- Counters:
  - cyc: 0..2*BCLK_HALF-1.
  - bit: 0..SLOT_BITS-1, advances when cyc wraps.
  - slot: 1 = left, 0 = right; toggles when bit wraps at cyc wrap.
- Frame = left slot followed by right slot = 4*SLOT_BITS*BCLK_HALF clk (256 at defaults).
- Reset values:
  - cyc = 0, bit = 0, slot = 1 (left).
  - Holding registers, rx shadows, rx_data_l/r and AUD_DACDAT = 0.
  - tx_ready = 0, rx_valid = 0.
- AUD_BCLK = (cyc >= BCLK_HALF): low for the first BCLK_HALF clk of each bit period, high for the rest.
- AUD_DACLRCK = AUD_ADCLRCK = slot, in both modes.
- Bit index: k = bit - I2S_MODE. Bit is valid when 0 <= k < SAMPLE_WIDTH; sample bit sent/received = SAMPLE_WIDTH-1-k (MSB first).
- TX side:
  - tx_ready = 1 in the last clk of each frame (cyc max, bit max, slot = 0).
  - In that cycle tx_data_l/r are captured into holding registers, used for the whole next frame.
  - First frame after reset transmits zeros.
- AUD_DACDAT is registered and updated in the cycle cyc wraps to 0 (coincident with the BCLK falling edge).
  - Value = selected holding bit if the bit is valid and channel_en[slot] = 1, else 0.
  - Held for the full bit period.
- RX side:
  - AUD_ADCDAT sampled in the cycle cyc == BCLK_HALF (first clk of BCLK high), only for valid bits of enabled channels, into per-channel shadow registers.
  - Bits outside the valid range are ignored.
- RX publish, in the last clk of each frame:
  - rx_data_l <= left shadow if channel_en[1], else unchanged.
  - rx_data_r <= right shadow if channel_en[0], else unchanged.
  - rx_valid = 1 for that single cycle, even if both channels are disabled.
  - Outputs are registered: the new rx_data values and the rx_valid strobe become visible in the same cycle.
  - Shadows are zeroed at the start of their slot.
- Simultaneous events: tx_ready and rx_valid coincide every frame; tx capture and rx publish happen in the same cycle without interaction.
- channel_en is sampled per bit; changing it mid-slot affects only subsequent bits. Responsibility for clean switching lies with the user.
- Reset mid-frame:
  - Immediate return to reset state; partial rx shadows are discarded.
  - No rx_valid or tx_ready is issued for the aborted frame.
  - LRCK returns to 1 and BCLK to 0 the cycle after reset is sampled.
- Loopback latency (DACDAT to ADCDAT): sample captured on tx_ready of frame N appears on rx_data with rx_valid at the end of frame N+1.

Test Plan:
- Defaults, reset then run 3 frames -> BCLK period 8 clk, LRCK period 256 clk; tx_ready and rx_valid exactly one pulse per frame, at clk 255, 511, 767.
- tx_data_l=16'hA5C3, tx_data_r=16'h0F0F held -> in frame 2 DACDAT during left slot = 1010010111000011, right = 0000111100001111, each bit stable 8 clk and changing only with BCLK falling.
- Loopback AUD_ADCDAT=AUD_DACDAT with tx 16'h8001/16'h7FFE -> rx_data_l=16'h8001, rx_data_r=16'h7FFE at end of frame 2.
- channel_en=2'b10, loopback -> right-slot DACDAT all 0; rx_data_r keeps its previous value; rx_valid still pulses.
- I2S_MODE=1, SAMPLE_WIDTH=24, SLOT_BITS=32, tx_data_l=24'h800000 -> DACDAT 0 in bit 0 and 1 only in bit 1 of the left slot; frame = 512 clk.
- Assert reset for 1 clk at clk 100 of a frame -> all outputs at reset values the next cycle; next tx_ready 256 clk after reset release; no rx_valid for the aborted frame.
